// File: rtl/bsg_manycore_arb_pkg.sv
// Shared types for the tile memory-port arbiter: arbitration modes and source encoding.
package bsg_manycore_arb_pkg;

  typedef enum logic [1:0] {
    FIXED_CORE = 2'd0,
    FIXED_NET  = 2'd1,
    RR         = 2'd2,
    RR_ALT     = 2'd3
  } bsg_manycore_arb_mode_e;

  localparam logic SRC_CORE = 1'b0;
  localparam logic SRC_NET  = 1'b1;

  function automatic logic is_fixed_mode(input bsg_manycore_arb_mode_e mode);
    return (mode == FIXED_CORE) || (mode == FIXED_NET);
  endfunction

endpackage

// File: rtl/bsg_manycore_arb_2.sv
// Two-way (network vs core) grant logic with round-robin pointer and, when
// BSG_MANYCORE_ARB_STARVE_GUARD_EN is defined, per-side starvation counters.
module bsg_manycore_arb_2
  import bsg_manycore_arb_pkg::*;
#(
  parameter int starve_limit_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  bsg_manycore_arb_mode_e mode_i,
  input  logic                   net_req_i,
  input  logic                   core_req_i,
  output logic                   net_gnt_o,
  output logic                   core_gnt_o
);

  logic last_net_q;
  logic net_win;

`ifdef BSG_MANYCORE_ARB_STARVE_GUARD_EN
  localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

  logic [cnt_width_lp-1:0] net_cnt_q, core_cnt_q;
  logic net_starved, core_starved;

  assign net_starved  = (net_cnt_q == limit_lp);
  assign core_starved = (core_cnt_q == limit_lp);

  // Counters only track losses under fixed priority; round-robin cannot starve.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      net_cnt_q  <= '0;
      core_cnt_q <= '0;
    end else if (!is_fixed_mode(mode_i)) begin
      net_cnt_q  <= '0;
      core_cnt_q <= '0;
    end else begin
      if (net_gnt_o) net_cnt_q <= '0;
      else if (net_req_i && core_gnt_o && !net_starved) net_cnt_q <= net_cnt_q + 1'b1;
      if (core_gnt_o) core_cnt_q <= '0;
      else if (core_req_i && net_gnt_o && !core_starved) core_cnt_q <= core_cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    // NOTE: assign a default first so every path drives net_win and no latch is inferred.
    net_win = 1'b0;
    case (mode_i)
      FIXED_CORE: net_win = 1'b0;
      FIXED_NET:  net_win = 1'b1;
      default:    net_win = !last_net_q;
    endcase
`ifdef BSG_MANYCORE_ARB_STARVE_GUARD_EN
    if (is_fixed_mode(mode_i)) begin
      if (core_starved)     net_win = 1'b0;
      else if (net_starved) net_win = 1'b1;
    end
`endif
  end

  assign net_gnt_o  = net_req_i && (!core_req_i || net_win);
  assign core_gnt_o = core_req_i && (!net_req_i || !net_win);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)         last_net_q <= 1'b0;
    else if (net_gnt_o)  last_net_q <= 1'b1;
    else if (core_gnt_o) last_net_q <= 1'b0;
  end

endmodule

// File: rtl/bsg_manycore_mem_arb_ctrl.sv
// Tile-side memory-port controller: config registers, network/core arbitration and a
// one-entry registered memory stage. Optional starvation guard: BSG_MANYCORE_ARB_STARVE_GUARD_EN.
module bsg_manycore_mem_arb_ctrl
  import bsg_manycore_arb_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 10,
  parameter int starve_limit_p = 16,
  parameter int cnt_width_p    = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       net_v_i,
  input  logic                       net_remote_store_i,
  input  logic                       net_freeze_i,
  input  logic                       net_unfreeze_i,
  input  logic                       net_arb_cfg_i,
  input  logic                       net_unknown_i,
  input  logic [data_width_p-1:0]    net_data_i,
  input  logic [addr_width_p-1:0]    net_addr_i,
  input  logic [(data_width_p>>3)-1:0] net_mask_i,
  output logic                       net_yumi_o,
  input  logic                       core_v_i,
  input  logic                       core_w_i,
  input  logic [addr_width_p-1:0]    core_addr_i,
  input  logic [data_width_p-1:0]    core_data_i,
  input  logic [(data_width_p>>3)-1:0] core_mask_i,
  output logic                       core_yumi_o,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_p-1:0]    mem_addr_o,
  output logic [data_width_p-1:0]    mem_data_o,
  output logic [(data_width_p>>3)-1:0] mem_mask_o,
  output logic                       mem_src_o,
  input  logic                       mem_yumi_i,
  output logic                       freeze_o,
  output logic [1:0]                 arb_mode_o,
  output logic [cnt_width_p-1:0]     unknown_cnt_o
);

  logic                   freeze_q;
  bsg_manycore_arb_mode_e arb_mode_q;
  logic [cnt_width_p-1:0] unknown_cnt_q;

  logic net_store, cfg_freeze, cfg_unfreeze, cfg_arb, cfg_unknown, cfg_v;
  logic stage_open, net_gnt, core_gnt;

  // Decode flags are resolved by priority in case more than one is set.
  assign net_store    = net_v_i && net_remote_store_i;
  assign cfg_freeze   = net_v_i && !net_remote_store_i && net_freeze_i;
  assign cfg_unfreeze = net_v_i && !net_remote_store_i && !net_freeze_i && net_unfreeze_i;
  assign cfg_arb      = net_v_i && !net_remote_store_i && !net_freeze_i && !net_unfreeze_i
                        && net_arb_cfg_i;
  assign cfg_unknown  = net_v_i && !net_remote_store_i && !net_freeze_i && !net_unfreeze_i
                        && !net_arb_cfg_i && net_unknown_i;
  assign cfg_v        = cfg_freeze || cfg_unfreeze || cfg_arb || cfg_unknown;

  assign stage_open = !mem_v_o || mem_yumi_i;

  bsg_manycore_arb_2 #(.starve_limit_p(starve_limit_p)) arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .mode_i     (arb_mode_q),
    .net_req_i  (net_store && stage_open),
    .core_req_i (core_v_i && !freeze_q && stage_open),
    .net_gnt_o  (net_gnt),
    .core_gnt_o (core_gnt)
  );

  // Config packets drain regardless of the memory stage.
  assign net_yumi_o  = !reset_i && (net_gnt || cfg_v);
  assign core_yumi_o = core_gnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      freeze_q      <= 1'b1;
      arb_mode_q    <= RR;
      unknown_cnt_q <= '0;
    end else begin
      if (cfg_freeze)   freeze_q <= 1'b1;
      if (cfg_unfreeze) freeze_q <= 1'b0;
      if (cfg_arb)      arb_mode_q <= bsg_manycore_arb_mode_e'(net_data_i[1:0]);
      if (cfg_unknown && (unknown_cnt_q != '1)) unknown_cnt_q <= unknown_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_v_o    <= 1'b0;
      mem_w_o    <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_mask_o <= '0;
      mem_src_o  <= SRC_CORE;
    end else if (net_gnt) begin
      mem_v_o    <= 1'b1;
      mem_w_o    <= 1'b1;
      mem_addr_o <= net_addr_i;
      mem_data_o <= net_data_i;
      mem_mask_o <= net_mask_i;
      mem_src_o  <= SRC_NET;
    end else if (core_gnt) begin
      mem_v_o    <= 1'b1;
      mem_w_o    <= core_w_i;
      mem_addr_o <= core_addr_i;
      mem_data_o <= core_data_i;
      mem_mask_o <= core_mask_i;
      mem_src_o  <= SRC_CORE;
    end else if (mem_yumi_i) begin
      mem_v_o    <= 1'b0;
    end
  end

  assign freeze_o      = freeze_q;
  assign arb_mode_o    = arb_mode_q;
  assign unknown_cnt_o = unknown_cnt_q;

endmodule

// File: tb/tb_bsg_manycore_mem_arb_ctrl.sv
// Scoreboard bench for bsg_manycore_mem_arb_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model; honours BSG_MANYCORE_ARB_STARVE_GUARD_EN.
module tb_bsg_manycore_mem_arb_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int MW  = DW >> 3;
  localparam int LIM = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          net_v_i, net_remote_store_i, net_freeze_i, net_unfreeze_i, net_arb_cfg_i, net_unknown_i;
  logic [DW-1:0] net_data_i;
  logic [AW-1:0] net_addr_i;
  logic [MW-1:0] net_mask_i;
  logic          net_yumi_o;
  logic          core_v_i, core_w_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_data_i;
  logic [MW-1:0] core_mask_i;
  logic          core_yumi_o;
  logic          mem_v_o, mem_w_o, mem_src_o, mem_yumi_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [MW-1:0] mem_mask_o;
  logic          freeze_o;
  logic [1:0]    arb_mode_o;
  logic [CW-1:0] unknown_cnt_o;

  bsg_manycore_mem_arb_ctrl #(
    .data_width_p(DW), .addr_width_p(AW), .starve_limit_p(LIM), .cnt_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .net_v_i(net_v_i), .net_remote_store_i(net_remote_store_i), .net_freeze_i(net_freeze_i),
    .net_unfreeze_i(net_unfreeze_i), .net_arb_cfg_i(net_arb_cfg_i), .net_unknown_i(net_unknown_i),
    .net_data_i(net_data_i), .net_addr_i(net_addr_i), .net_mask_i(net_mask_i), .net_yumi_o(net_yumi_o),
    .core_v_i(core_v_i), .core_w_i(core_w_i), .core_addr_i(core_addr_i), .core_data_i(core_data_i),
    .core_mask_i(core_mask_i), .core_yumi_o(core_yumi_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_src_o(mem_src_o), .mem_yumi_i(mem_yumi_i),
    .freeze_o(freeze_o), .arb_mode_o(arb_mode_o), .unknown_cnt_o(unknown_cnt_o)
  );

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          src;
  } mem_txn_t;

  mem_txn_t exp_q[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state, kept in plain terms of what the tile is doing.
  bit m_frozen;
  int m_mode;
  bit m_stage_full;
  bit m_net_won_last;
  int m_net_losses, m_core_losses;
  int m_unknown;
  bit obs_core_yumi;

  task automatic model_reset();
    m_frozen = 1; m_mode = 2; m_stage_full = 0; m_net_won_last = 0;
    m_net_losses = 0; m_core_losses = 0; m_unknown = 0;
    exp_q.delete();
  endtask

  task automatic idle();
    net_v_i = 0; net_remote_store_i = 0; net_freeze_i = 0; net_unfreeze_i = 0;
    net_arb_cfg_i = 0; net_unknown_i = 0; net_data_i = '0; net_addr_i = '0; net_mask_i = '0;
    core_v_i = 0; core_w_i = 0; core_addr_i = '0; core_data_i = '0; core_mask_i = '0;
    mem_yumi_i = 0;
  endtask

  // Inputs for the cycle are already driven; check at the falling edge, advance the model.
  task automatic step();
    bit open, net_el, core_el, net_wins, net_g, core_g;
    int kind;
    @(negedge clk);
    check("freeze_o", freeze_o, m_frozen);
    check("arb_mode_o", arb_mode_o, m_mode);
    check("unknown_cnt_o", unknown_cnt_o, m_unknown);
    check("mem_v_o", mem_v_o, m_stage_full);
    open    = !m_stage_full || mem_yumi_i;
    net_el  = net_v_i && net_remote_store_i && open;
    core_el = core_v_i && !m_frozen && open;
    if (m_mode >= 2) net_wins = !m_net_won_last;
    else begin
      net_wins = (m_mode == 1);
`ifdef BSG_MANYCORE_ARB_STARVE_GUARD_EN
      if (m_core_losses >= LIM)     net_wins = 0;
      else if (m_net_losses >= LIM) net_wins = 1;
`endif
    end
    net_g  = net_el && (!core_el || net_wins);
    core_g = core_el && !net_g;
    kind = 0;
    if (net_v_i && !net_remote_store_i) begin
      if (net_freeze_i) kind = 1;
      else if (net_unfreeze_i) kind = 2;
      else if (net_arb_cfg_i) kind = 3;
      else if (net_unknown_i) kind = 4;
    end
    check("net_yumi_o", net_yumi_o, net_g || (kind != 0));
    check("core_yumi_o", core_yumi_o, core_g);
    obs_core_yumi = core_yumi_o;
    if (net_g)       exp_q.push_back('{1'b1, net_addr_i, net_data_i, net_mask_i, 1'b1});
    else if (core_g) exp_q.push_back('{core_w_i, core_addr_i, core_data_i, core_mask_i, 1'b0});
    if (net_g || core_g) m_stage_full = 1;
    else if (mem_yumi_i) m_stage_full = 0;
    if (net_g) m_net_won_last = 1;
    else if (core_g) m_net_won_last = 0;
    if (m_mode >= 2) begin
      m_net_losses = 0; m_core_losses = 0;
    end else begin
      if (net_g) m_net_losses = 0;
      else if (net_el && core_g) m_net_losses++;
      if (core_g) m_core_losses = 0;
      else if (core_el && net_g) m_core_losses++;
    end
    case (kind)
      1: m_frozen = 1;
      2: m_frozen = 0;
      3: m_mode = int'(net_data_i[1:0]);
      4: if (m_unknown < 255) m_unknown++;
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int kind, input logic [DW-1:0] data);
    idle();
    net_v_i = 1; net_data_i = data;
    net_freeze_i = (kind == 1); net_unfreeze_i = (kind == 2);
    net_arb_cfg_i = (kind == 3); net_unknown_i = (kind == 4);
    mem_yumi_i = 1;
    step();
  endtask

  task automatic both_req(input logic yumi);
    net_v_i = 1; net_remote_store_i = 1; net_freeze_i = 0; net_unfreeze_i = 0;
    net_arb_cfg_i = 0; net_unknown_i = 0;
    net_data_i = $urandom; net_addr_i = AW'($urandom); net_mask_i = MW'($urandom);
    core_v_i = 1; core_w_i = 1'($urandom); core_data_i = $urandom;
    core_addr_i = AW'($urandom); core_mask_i = MW'($urandom);
    mem_yumi_i = yumi;
  endtask

  // Monitor: pops the scoreboard on every accepted memory request, checks hold under stall.
  bit       stall_prev = 0;
  mem_txn_t held;
  always @(negedge clk) begin
    mem_txn_t cur, t;
    cur = '{mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, mem_src_o};
    if (reset_i) stall_prev = 0;
    else begin
      if (stall_prev && mem_v_o) check("mem_hold", cur, held);
      if (mem_v_o && mem_yumi_i) begin
        if (exp_q.size() == 0) check("mem_unexpected", 1, 0);
        else begin
          t = exp_q.pop_front();
          check("mem_txn", cur, t);
        end
      end
      stall_prev = mem_v_o && !mem_yumi_i;
      held = cur;
    end
  end

  initial begin
    int first_core, k;
    idle();
    model_reset();
    reset_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_freeze", freeze_o, 1);
    check("rst_mode", arb_mode_o, 2);
    check("rst_cnt", unknown_cnt_o, 0);
    check("rst_mem_v", mem_v_o, 0);
    check("rst_mem_fields", {mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, mem_src_o}, 0);
    reset_i = 0;
    @(posedge clk); #1;

    // Frozen after reset, then unfreeze lets the core through.
    idle(); core_v_i = 1; core_addr_i = 10'h55; core_data_i = 32'hC0DE_0001; core_mask_i = 4'hF;
    step();
    net_v_i = 1; net_unfreeze_i = 1; step();
    net_v_i = 0; net_unfreeze_i = 0; step();
    check("unfreeze_core_yumi", obs_core_yumi, 1);
    idle(); mem_yumi_i = 1; step(); step();

    // Round robin under continuous contention.
    cfg(3, 32'd2);
    repeat (4) begin both_req(1); step(); end
    idle(); mem_yumi_i = 1; step();

    // Core fixed priority with a stalled memory stage.
    cfg(3, 32'd0);
    both_req(0); step();
    repeat (5) step();
    idle(); mem_yumi_i = 1; step(); step();

    // Freeze in the same cycle as a core request.
    idle(); mem_yumi_i = 1; core_v_i = 1; core_addr_i = 10'h3A; net_v_i = 1; net_freeze_i = 1;
    step();
    net_v_i = 0; net_freeze_i = 0; step();
    check("frozen_core_blocked", obs_core_yumi, 0);
    check("frozen_flag", freeze_o, 1);
    cfg(2, '0);

    // Saturating unknown-packet counter.
    for (int i = 0; i < 300; i++) cfg(4, $urandom);
    idle(); step();
    check("unknown_saturated", unknown_cnt_o, 255);

    // Network fixed priority: starvation guard behaviour.
    cfg(3, 32'd1);
    first_core = 0;
    for (int i = 1; i <= 8; i++) begin
      both_req(1); step();
      if (obs_core_yumi && first_core == 0) first_core = i;
    end
`ifdef BSG_MANYCORE_ARB_STARVE_GUARD_EN
    check("starve_first_core_grant", first_core, 5);
`else
    check("starve_first_core_grant", first_core, 0);
`endif
    idle(); mem_yumi_i = 1; step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      idle();
      if ($urandom_range(0, 99) < 60) begin
        net_v_i = 1;
        net_data_i = $urandom; net_addr_i = AW'($urandom); net_mask_i = MW'($urandom);
        k = $urandom_range(0, 11);
        if (k <= 5) net_remote_store_i = 1;
        else if (k == 6) net_freeze_i = 1;
        else if (k <= 8) net_unfreeze_i = 1;
        else if (k == 9) net_arb_cfg_i = 1;
        else if (k == 10) net_unknown_i = 1;
        else begin
          {net_remote_store_i, net_freeze_i, net_unfreeze_i, net_arb_cfg_i, net_unknown_i} = 5'($urandom);
          if (!(net_remote_store_i || net_freeze_i || net_unfreeze_i || net_arb_cfg_i || net_unknown_i))
            net_remote_store_i = 1;
        end
      end
      core_v_i = 1'($urandom); core_w_i = 1'($urandom);
      core_addr_i = AW'($urandom); core_data_i = $urandom; core_mask_i = MW'($urandom);
      mem_yumi_i = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(); mem_yumi_i = 1; step(); step();

    // Reset while a request is buffered drops it.
    idle(); net_v_i = 1; net_remote_store_i = 1; net_addr_i = 10'h2AA; net_data_i = 32'hDEAD_BEEF;
    mem_yumi_i = 0;
    step();
    idle();
    reset_i = 1;
    #2;
    check("midrst_mem_v", mem_v_o, 0);
    check("midrst_freeze", freeze_o, 1);
    model_reset();
    @(negedge clk);
    reset_i = 0;
    @(posedge clk); #1;
    idle(); mem_yumi_i = 1;
    repeat (3) step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
